// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Byte-address width of the memory ports; the read port and the loader both use this.
    function automatic int addr_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: lane byte_idx takes each accepted byte.
// Latency: word_nxt is combinational; the lane register updates on the accepting edge.
// Backpressure: none of its own; the caller qualifies every byte with accept.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_nxt,
    output logic        word_full
);

    logic [31:0] word;
    logic [1:0]  byte_idx;

    // Merge the incoming byte into its lane so the 4th byte is visible the cycle it arrives.
    always_comb begin
        word_nxt = word;
        case (byte_idx)
            2'd0:    word_nxt[7:0]   = byte_data;
            2'd1:    word_nxt[15:8]  = byte_data;
            2'd2:    word_nxt[23:16] = byte_data;
            default: word_nxt[31:24] = byte_data;
        endcase
    end

    // Word completes when the top lane is being filled by an accepted byte.
    assign word_full = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

    // Lane register and index; the index wraps naturally after the 4th byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (accept) begin
            word     <= word_nxt;
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader: packs bytes into 32-bit words, writes them from word 0, releases cpu_hold when done.
// Latency: we one cycle after the 4th byte of a word; 5 cycles/word at full rate; done one cycle after last we.
// Backpressure: byte_ready only in COLLECT; the source is stalled in IDLE, WRITE and DONE.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(DEPTH):0]       word_count,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         we,
    output logic [addr_width(DEPTH)-1:0] waddr,
    output logic [31:0]                  wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         cpu_hold,
    output logic                         err_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    state_t         state;
    logic [CW-1:0]  count;
    logic [IW-1:0]  word_idx;
    logic           accept;
    logic           legal_start;
    logic           word_full;
    logic [31:0]    word_nxt;

    assign accept      = byte_valid && byte_ready;
    assign legal_start = (state == ST_IDLE) && start &&
                         (word_count != '0) && (word_count <= DEPTH_W);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (legal_start),
        .accept    (accept),
        .byte_data (byte_data),
        .word_nxt  (word_nxt),
        .word_full (word_full)
    );

    // Load sequencer; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            word_idx   <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_hold   <= HOLD_AT_RESET;
            err_count  <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count > DEPTH_W) begin
                            // Oversized request: flag it and stay put, core hold untouched.
                            err_count <= 1'b1;
                        end else if (word_count == '0) begin
                            err_count <= 1'b0;
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            err_count  <= 1'b0;
                            count      <= word_count;
                            word_idx   <= '0;
                            cpu_hold   <= 1'b1;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state      <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (word_full) begin
                        byte_ready <= 1'b0;
                        we         <= 1'b1;
                        waddr      <= {word_idx, 2'b00};
                        wdata      <= word_nxt;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if ({1'b0, word_idx} == count - CW'(1)) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        word_idx   <= word_idx + IW'(1);
                        byte_ready <= 1'b1;
                        state      <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboarded write checks plus per-scenario timing/state checks.
// Latency: expects we one cycle after the 4th byte and done one cycle after the last we.
// Backpressure: drives bytes only when byte_ready is sampled high.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, we, busy, done, cpu_hold, err_count;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            we_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_we_cyc = 0;
    int            prev_we_cyc = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [31:0]   mem [0:DEPTH-1];
    bit            stalled = 1'b0;

    imem_loader #(.DEPTH(DEPTH), .HOLD_AT_RESET(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write monitor: model memory, scoreboard compare, timing bookkeeping.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (we === 1'b1) begin
            we_cnt++;
            prev_we_cyc = last_we_cyc;
            last_we_cyc = cyc;
            last_waddr  = waddr;
            mem[waddr[AW-1:2]] = wdata;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_we waddr=%0d wdata=%h required no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== e.addr || wdata !== e.data) begin
                    bad++;
                    $display("FAIL sb_write waddr=%0d wdata=%h required waddr=%0d wdata=%h",
                             waddr, wdata, e.addr, e.data);
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [8:0] n);
        word_count = n;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] d);
        exp_t e;
        e.addr = AW'(idx * 4);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (stalled) return;
        byte_valid = 1'b1;
        byte_data  = b;
        while (1) begin
            @(negedge clk);
            if (byte_ready === 1'b1) break;
            n++;
            if (n > 20) begin
                total++;
                bad++;
                $display("FAIL byte_accept_timeout data=%h byte_ready=%b required 1", b, byte_ready);
                stalled    = 1'b1;
                byte_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
            if (n > bound) begin
                total++;
                bad++;
                $display("FAIL done_timeout done=%b required 1 within %0d cycles", done, bound);
                break;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h01010101 * 32'(i) + 32'h00010203;
    endfunction

    task automatic test_reset();
        total++;
        if (byte_ready !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            err_count !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl rdy=%b we=%b busy=%b done=%b err=%b hold=%b required 0 0 0 0 0 1",
                     byte_ready, we, busy, done, err_count, cpu_hold);
        end
        total++;
        if (waddr !== '0 || wdata !== '0) begin
            bad++;
            $display("FAIL reset_data waddr=%0d wdata=%h required 0 0", waddr, wdata);
        end
    endtask

    task automatic test_two_words();
        int w0, d0;
        w0 = we_cnt;
        d0 = done_cnt;
        stalled = 1'b0;
        push_exp(0, 32'h00000013);
        push_exp(1, 32'h00100093);
        pulse_start(9'd2);
        total++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL two_collect hold=%b busy=%b rdy=%b required 1 1 1", cpu_hold, busy, byte_ready);
        end
        send_word(32'h00000013);
        send_word(32'h00100093);
        byte_valid = 1'b0;
        wait_done(20);
        total++;
        if (we_cnt - w0 != 2) begin
            bad++;
            $display("FAIL two_we_count got=%0d required 2", we_cnt - w0);
        end
        total++;
        if (last_we_cyc - prev_we_cyc != 5) begin
            bad++;
            $display("FAIL two_word_spacing got=%0d cycles required 5", last_we_cyc - prev_we_cyc);
        end
        total++;
        if (done_cyc - last_we_cyc != 1) begin
            bad++;
            $display("FAIL two_done_latency got=%0d required 1", done_cyc - last_we_cyc);
        end
        total++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL two_release hold=%b busy=%b required 0 0", cpu_hold, busy);
        end
        step();
        total++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL two_done_pulse done=%b pulses=%0d required 0 1", done, done_cnt - d0);
        end
    endtask

    task automatic test_throttled();
        int w0;
        logic [31:0] d;
        w0 = we_cnt;
        stalled = 1'b0;
        d = 32'hDEADBEEF;
        push_exp(0, d);
        pulse_start(9'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(d[8*i +: 8]);
            if (i < 3) begin
                byte_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    total++;
                    if (byte_ready !== 1'b1) begin
                        bad++;
                        $display("FAIL throttle_ready byte=%0d rdy=%b required 1", i, byte_ready);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
        byte_valid = 1'b0;
        wait_done(20);
        total++;
        if (we_cnt - w0 != 1 || last_waddr !== 10'd0) begin
            bad++;
            $display("FAIL throttle_write count=%0d waddr=%0d required 1 0", we_cnt - w0, last_waddr);
        end
        step();
    endtask

    task automatic test_full_depth();
        int w0, d0, errs;
        w0 = we_cnt;
        d0 = done_cnt;
        stalled = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_exp(i, pat(i));
        pulse_start(9'd256);
        for (int i = 0; i < DEPTH; i++) send_word(pat(i));
        byte_valid = 1'b0;
        wait_done(40);
        total++;
        if (we_cnt - w0 != DEPTH) begin
            bad++;
            $display("FAIL full_we_count got=%0d required %0d", we_cnt - w0, DEPTH);
        end
        total++;
        if (last_waddr !== 10'd1020) begin
            bad++;
            $display("FAIL full_last_addr got=%0d required 1020", last_waddr);
        end
        repeat (5) step();
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL full_done_once got=%0d required 1", done_cnt - d0);
        end
        errs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== pat(i)) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL full_readback bad_words=%0d required 0 (mem[0]=%h mem[255]=%h)",
                     errs, mem[0], mem[255]);
        end
    endtask

    task automatic test_zero_and_err();
        int w0, d0;
        w0 = we_cnt;
        d0 = done_cnt;
        stalled = 1'b0;
        pulse_start(9'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done done=%b busy=%b required 1 0", done, busy);
        end
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_done_pulse done=%b required 0", done);
        end
        repeat (3) step();
        total++;
        if (we_cnt != w0 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL zero_no_write writes=%0d dones=%0d required 0 1", we_cnt - w0, done_cnt - d0);
        end
        pulse_start(9'd300);
        total++;
        if (err_count !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL err_set err=%b busy=%b rdy=%b hold=%b required 1 0 0 0",
                     err_count, busy, byte_ready, cpu_hold);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (5) step();
        byte_valid = 1'b0;
        total++;
        if (err_count !== 1'b1 || we_cnt != w0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL err_sticky err=%b writes=%0d busy=%b done=%b required 1 0 0 0",
                     err_count, we_cnt - w0, busy, done);
        end
        push_exp(0, 32'h12345678);
        pulse_start(9'd1);
        total++;
        if (err_count !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL err_clear err=%b busy=%b hold=%b required 0 1 1", err_count, busy, cpu_hold);
        end
        send_word(32'h12345678);
        byte_valid = 1'b0;
        wait_done(20);
        step();
    endtask

    task automatic test_ignored_inputs();
        int w0, d0;
        w0 = we_cnt;
        d0 = done_cnt;
        stalled = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (4) step();
        byte_valid = 1'b0;
        total++;
        if (we_cnt != w0 || wdata !== 32'h12345678 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_bytes writes=%0d wdata=%h rdy=%b required 0 12345678 0",
                     we_cnt - w0, wdata, byte_ready);
        end
        push_exp(0, 32'h0BADF00D);
        pulse_start(9'd1);
        send_byte(8'h0D);
        send_byte(8'hF0);
        byte_valid = 1'b0;
        pulse_start(9'd2);
        total++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL collect_start busy=%b rdy=%b required 1 1", busy, byte_ready);
        end
        send_byte(8'hAD);
        send_byte(8'h0B);
        byte_valid = 1'b0;
        wait_done(20);
        step();
        total++;
        if (we_cnt - w0 != 1 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL collect_start_ignored writes=%0d dones=%0d required 1 1",
                     we_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        w0 = we_cnt;
        stalled = 1'b0;
        push_exp(0, 32'hCAFEF00D);
        pulse_start(9'd3);
        send_word(32'hCAFEF00D);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        total++;
        if (we !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0 ||
            err_count !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL abort_ctrl we=%b busy=%b rdy=%b done=%b err=%b hold=%b required 0 0 0 0 0 1",
                     we, busy, byte_ready, done, err_count, cpu_hold);
        end
        total++;
        if (waddr !== '0 || wdata !== '0) begin
            bad++;
            $display("FAIL abort_data waddr=%0d wdata=%h required 0 0", waddr, wdata);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        byte_valid = 1'b0;
        total++;
        if (we_cnt - w0 != 1 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL abort_quiet writes=%0d busy=%b hold=%b required 1 0 1",
                     we_cnt - w0, busy, cpu_hold);
        end
        total++;
        if (mem[0] !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL abort_word0 got=%h required cafef00d", mem[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        step();
        test_two_words();
        test_throttled();
        test_full_depth();
        test_zero_and_err();
        test_ignored_inputs();
        test_reset_abort();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory read port.
- Accepts a byte stream through a valid/ready handshake, for example from a UART receiver or debug host.
- Packs the bytes little-endian into 32-bit instructions and writes them sequentially to the instruction memory write port, starting at word 0.
- Holds the CPU core in stall/reset through cpu_hold until a programmed word count has been written.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words. Must be a power of two.
- HOLD_AT_RESET, 1, reset value of cpu_hold. 1 keeps the core held until the first load completes.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle load request; sampled only in IDLE
- word_count  input  $clog2(DEPTH)+1  number of words to load, legal 0..DEPTH; sampled with start
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- we  output  1  instruction memory write enable, one cycle per word
- waddr  output  $clog2(DEPTH)+2  byte address, same width as the read-port address; waddr[1:0] always 2'b00
- wdata  output  32  packed instruction
- busy  output  1  high in COLLECT and WRITE
- done  output  1  one-cycle pulse at load completion
- cpu_hold  output  1  core stall/hold request
- err_count  output  1  sticky; set when word_count > DEPTH

Behaviour:
Reset:
- State IDLE.
- byte_ready, we, busy, done, err_count = 0.
- waddr = 0, wdata = 0.
- cpu_hold = HOLD_AT_RESET.
- Internal word index, byte index and assembly register = 0.
- All outputs are registered.

States: IDLE, COLLECT, WRITE, DONE.

IDLE:
- byte_ready = 0; input bytes are ignored.
- start with 1 <= word_count <= DEPTH:
  - latch the count; clear the word index, byte index and err_count
  - set cpu_hold = 1
  - go to COLLECT
- start with word_count == 0: go to DONE with no writes; clear err_count.
- start with word_count > DEPTH: set err_count = 1, stay in IDLE, leave cpu_hold unchanged.

COLLECT:
- byte_ready = 1.
- On byte_valid && byte_ready, write the byte into lane byte_idx of the assembly register (first byte goes to [7:0], fourth to [31:24]), then increment byte_idx modulo 4.
- On acceptance of the 4th byte, go to WRITE.
- No timeout; the loader waits indefinitely for bytes.

WRITE (exactly one cycle):
- we = 1, waddr = {word_idx, 2'b00}, wdata = assembly register, byte_ready = 0.
- If word_idx == count-1, go to DONE. Otherwise increment word_idx and return to COLLECT.

DONE (one cycle):
- done = 1, cpu_hold = 0, then go to IDLE.

Throughput and latency:
- Continuous byte_valid gives 5 cycles per word: 4 accept cycles plus 1 write cycle.
- The first we occurs in the cycle after the 4th byte is accepted.
- done is asserted 1 cycle after the last we.

Boundary rules:
- start outside IDLE is ignored.
- word_count == DEPTH writes the last word at waddr = 4*(DEPTH-1). The word index never wraps.
- At most one byte is accepted per cycle.
- byte_data is don't-care when byte_valid is low or byte_ready is low.
- rst_n assertion mid-load aborts immediately:
  - we drops asynchronously
  - no further writes occur
  - memory words already written keep their values; later words are undefined
  - a partially assembled word is discarded
- err_count clears only on a legal start.

Decomposition:
- Package imem_pkg holds:
  - state enum (IDLE, COLLECT, WRITE, DONE)
  - BYTES_PER_WORD = 4
  - the shared DEPTH default and the address-width function, so that the loader and the instruction memory agree on the waddr/A width
- One natural sub-module: imem_word_packer. It contains the byte-lane register, byte_idx counter and word_full flag.
- The FSM, counters and memory-port outputs stay in imem_loader.

Test Plan:
- Reset release, then start with word_count=2 and continuous bytes 13,00,00,00,93,00,10,00:
  - we in exactly 2 cycles: waddr=0 wdata=32'h00000013, then waddr=4 wdata=32'h00100093
  - done pulse 1 cycle after the last we; cpu_hold 1→0
- Throttled source with a gap of 3 idle cycles between bytes, word_count=1, bytes EF,BE,AD,DE:
  - single we with wdata=32'hDEADBEEF, waddr=0
  - byte_ready high throughout COLLECT
- word_count=DEPTH (256), incrementing word pattern:
  - 256 writes, last at waddr=1020
  - read port returns each word
  - no wrap; done once
- word_count=0 → done the next cycle, no we. word_count=300 → err_count=1, no state change, no we. A legal start then clears err_count.
- Assert rst_n low after 2 bytes of word 1 (word 0 already written):
  - we never asserts again
  - outputs return to reset values, cpu_hold=HOLD_AT_RESET
  - word 0 is intact in memory
- start pulsed during COLLECT, and byte_valid high during IDLE/WRITE: both ignored, no byte consumed, wdata unaffected.
